// File: rtl/tc_period_checker.sv
// Terminal-count interval monitor: measures cycles between tc events from a
// counter chain, compares each interval with EXP_PERIOD +/- TOL, tracks status.
module tc_period_checker #(
    parameter int CNT_W      = 32,
    parameter int EXP_PERIOD = 65536,
    parameter int TOL        = 0,
    parameter int TIMEOUT    = 131072
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             tc_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic [15:0]      pulse_cnt,
    output logic [7:0]       err_cnt,
    output logic             err,
    output logic             timeout,
    output logic             busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;

    localparam logic [CNT_W:0]   EXP_EXT   = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_EXT   = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic [15:0]      pulse_cnt_q, pulse_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    // Deviation is taken one bit wider than the timer so the subtraction never wraps.
    logic [CNT_W:0] timer_ext;
    logic [CNT_W:0] deviation;
    logic           out_of_tol;
    logic [15:0]    pulse_cnt_inc;
    logic [7:0]     err_cnt_inc;

    assign timer_ext     = {1'b0, timer_q};
    assign deviation     = (timer_ext >= EXP_EXT) ? (timer_ext - EXP_EXT) : (EXP_EXT - timer_ext);
    assign out_of_tol    = (deviation > TOL_EXT) || (timer_q == TIMER_MAX);
    assign pulse_cnt_inc = (pulse_cnt_q == 16'hFFFF) ? pulse_cnt_q : pulse_cnt_q + 16'd1;
    assign err_cnt_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        pulse_cnt_d    = pulse_cnt_q;
        err_cnt_d      = err_cnt_q;
        err_d          = err_q;
        timeout_d      = timeout_q;

        if (start) begin
            state_d     = S_ARMED;
            timer_d     = '0;
            period_d    = '0;
            pulse_cnt_d = '0;
            err_cnt_d   = '0;
            err_d       = 1'b0;
            timeout_d   = 1'b0;
        end else if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (tc_in) begin
                        state_d     = S_MEASURE;
                        timer_d     = CNT_W'(1);
                        pulse_cnt_d = pulse_cnt_inc;
                    end
                end
                S_MEASURE: begin
                    if (tc_in) begin
                        period_d       = timer_q;
                        period_valid_d = 1'b1;
                        pulse_cnt_d    = pulse_cnt_inc;
                        timer_d        = CNT_W'(1);
                        if (out_of_tol) begin
                            err_cnt_d = err_cnt_inc;
                            err_d     = 1'b1;
                        end
                    end else if (timer_q >= TIMEOUT_C) begin
                        // The next tc after a timeout is a fresh reference, not an interval end.
                        state_d   = S_ARMED;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                    end else if (timer_q != TIMER_MAX) begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            pulse_cnt_q    <= '0;
            err_cnt_q      <= '0;
            err_q          <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            pulse_cnt_q    <= pulse_cnt_d;
            err_cnt_q      <= err_cnt_d;
            err_q          <= err_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign pulse_cnt    = pulse_cnt_q;
    assign err_cnt      = err_cnt_q;
    assign err          = err_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule
